intersection_model: RTL and testbench
=====================================

// Module: intersection_model
// PURPOSE
//  Synthesizable model of the intersection, sitting at the other end of the traffic-light
//  controller interface: consumes the controller's three light colours, drives its sensors.
//  - Per approach (ew_str, ew_left, ns): a queue of waiting cars.
//  - Car arrivals enter the queue as single-cycle pulses.
//  - Cars depart only on green, at a fixed spacing.
//  - Each sensor is asserted while its queue is non-empty.
//  Used closed-loop in controller benches and on-board demos.
// PARAMETERS
//  QDEPTH   7  max cars held per approach queue (>=1)
//  DEP_GAP  2  cycles between successive departures on one green (>=1)
//  CW       $clog2(QDEPTH+1)  derived; queue count width (localparam)
// PORTS
//  clk             in   1   system clock, all state on posedge
//  reset           in   1   synchronous, active-high
//  arrive_ew_str   in   1   one car arrives at e-w straight (1-cycle pulse)
//  arrive_ew_left  in   1   one car arrives at e-w left-turn lane
//  arrive_ns       in   1   one car arrives at n-s
//  ew_str_light    in   2   colors, from controller
//  ew_left_light   in   2   colors, from controller
//  ns_light        in   2   colors, from controller
//  ew_str_sensor   out  1   ew_str queue non-empty
//  ew_left_sensor  out  1   ew_left queue non-empty
//  ns_sensor       out  1   ns queue non-empty
//  q_ew_str        out  CW  cars waiting, e-w straight
//  q_ew_left       out  CW  cars waiting, e-w left
//  q_ns            out  CW  cars waiting, n-s
//  overflow        out  1   sticky: an arrival was dropped because a queue was full
//  conflict        out  1   sticky: safety violation seen (SAFETY_CHECK_EN only)
// BEHAVIOUR
//  - Reset: all queue counts 0, all sensors 0, overflow 0, conflict 0, gap counters 0.
//    Reset mid-operation discards queued cars.
//  - Sensors are combinational from the registered counts:
//    arrival pulse at edge N gives count+1 and sensor=1 after edge N.
//  - Departure enable per approach: light==green AND count!=0 AND gap counter==0.
//    - On a departure, the gap counter loads DEP_GAP-1.
//    - Otherwise the gap counter decrements toward 0.
//    - The gap counter forces to 0 whenever the light is not green, so the first car leaves
//      in the first green cycle.
//  - Yellow and red never release cars.
//  - Count update per cycle:
//    - arrive only: +1 if count<QDEPTH; if count==QDEPTH, hold and set overflow.
//    - depart only: -1.
//    - arrive and depart together: count unchanged, no overflow even when full.
//    - neither: hold.
//  - Count never wraps: no increment past QDEPTH, no decrement below 0.
//  - Light value 2'b11 (undefined colour) is treated as red for departures.
// CONFIGURATION
//  SAFETY_CHECK_EN defined:
//    - conflict sets on any cycle in which more than one light is non-red.
//    - conflict also sets on any light input equal to 2'b11.
//    - conflict also sets when a light goes green->red without a yellow cycle
//      (registered previous colour per light).
//    - Once set, conflict stays 1 until reset.
//  SAFETY_CHECK_EN undefined: conflict tied 0; no previous-colour registers.
// STRUCTURE
//  - light_package (shared): colors enum {red,yellow,green} is reused unchanged.
//    Add approach_t enum {EW_STR, EW_LEFT, NS}.
//  - approach_queue sub-module, instantiated 3x.
//    - Ports: clk, reset, arrive, light, count, sensor, drop.
//    - Contains the count and gap counter.
//  - Top level ORs the three drop outputs into overflow; safety checker logic lives in the top.
// TESTING
//  1. Reset 2 cycles, all lights red -> counts 0, sensors 0, overflow 0, conflict 0.
//  2. 3 arrive_ns pulses, lights red -> q_ns=3, ns_sensor=1 from the cycle after the first
//     pulse; q_ns stays 3.
//  3. q_ns=3, ns_light green for 6 cycles, DEP_GAP=2 -> departures on cycles 0, 2, 4;
//     q_ns reaches 0 and ns_sensor=0 after cycle 4.
//  4. 8 arrive_ew_left pulses, lights red -> q_ew_left=7, overflow=1;
//     an arrival and a departure together while full keep the count at 7.
//  5. SAFETY_CHECK_EN: ew_str_light and ns_light both green for one cycle -> conflict=1,
//     still 1 after the lights return legal.
//     Without the macro the same stimulus gives conflict=0.
//  6. Closed loop with the traffic controller; arrivals at all three approaches every 4 cycles
//     for 1000 ns -> no conflict, no overflow with QDEPTH=7, every queue drains to 0.

Source files
------------

// File: rtl/light_package.sv
// Shared light colour encoding and approach identifiers for the traffic-light
// controller and the intersection model.
package light_package;

    typedef enum logic [1:0] {
        red    = 2'b00,
        yellow = 2'b01,
        green  = 2'b10
    } colors;

    typedef enum logic [1:0] {
        EW_STR  = 2'd0,
        EW_LEFT = 2'd1,
        NS      = 2'd2
    } approach_t;

    localparam int unsigned NUM_APPROACH = 3;

    function automatic logic is_green(input logic [1:0] c);
        return c == green;
    endfunction

endpackage

// File: rtl/approach_queue.sv
// One approach of the intersection: a car count fed by arrival pulses and
// drained on green at one car every DEP_GAP cycles.
module approach_queue
    import light_package::*;
#(
    parameter int unsigned QDEPTH  = 7,
    parameter int unsigned DEP_GAP = 2,
    localparam int unsigned CW     = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arrive,
    input  logic [1:0]    light,
    output logic [CW-1:0] count,
    output logic          sensor,
    output logic          drop
);

    localparam int unsigned   GW       = (DEP_GAP > 1) ? $clog2(DEP_GAP) : 1;
    localparam logic [CW-1:0] FULL     = CW'(QDEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(DEP_GAP - 1);

    logic [CW-1:0] r_count;
    logic [GW-1:0] r_gap;
    logic          w_green;
    logic          w_depart;
    logic          w_full;

    // The undefined colour 2'b11 is not green, so it holds cars like red.
    assign w_green  = is_green(light);
    assign w_full   = (r_count == FULL);
    assign w_depart = w_green && (r_count != '0) && (r_gap == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_gap   <= '0;
        end else begin
            if (!w_green)
                r_gap <= '0;
            else if (w_depart)
                r_gap <= GAP_LOAD;
            else if (r_gap != '0)
                r_gap <= r_gap - GW'(1);

            case ({arrive, w_depart})
                2'b10: if (!w_full) r_count <= r_count + CW'(1);
                2'b01: r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count  = r_count;
    assign sensor = (r_count != '0);
    assign drop   = arrive && !w_depart && w_full;

endmodule

// File: rtl/intersection_model.sv
// Intersection model driven by the traffic-light controller: three approach
// queues, sticky overflow, and an optional safety checker (SAFETY_CHECK_EN).
module intersection_model
    import light_package::*;
#(
    parameter int unsigned QDEPTH  = 7,
    parameter int unsigned DEP_GAP = 2,
    localparam int unsigned CW     = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arrive_ew_str,
    input  logic          arrive_ew_left,
    input  logic          arrive_ns,
    input  logic [1:0]    ew_str_light,
    input  logic [1:0]    ew_left_light,
    input  logic [1:0]    ns_light,
    output logic          ew_str_sensor,
    output logic          ew_left_sensor,
    output logic          ns_sensor,
    output logic [CW-1:0] q_ew_str,
    output logic [CW-1:0] q_ew_left,
    output logic [CW-1:0] q_ns,
    output logic          overflow,
    output logic          conflict
);

    logic [1:0]              w_light [NUM_APPROACH];
    logic [NUM_APPROACH-1:0] w_drop;
    logic                    r_overflow;

    assign w_light[EW_STR]  = ew_str_light;
    assign w_light[EW_LEFT] = ew_left_light;
    assign w_light[NS]      = ns_light;

    approach_queue #(.QDEPTH(QDEPTH), .DEP_GAP(DEP_GAP)) u_q_ew_str (
        .clk    (clk),
        .reset  (reset),
        .arrive (arrive_ew_str),
        .light  (ew_str_light),
        .count  (q_ew_str),
        .sensor (ew_str_sensor),
        .drop   (w_drop[EW_STR])
    );

    approach_queue #(.QDEPTH(QDEPTH), .DEP_GAP(DEP_GAP)) u_q_ew_left (
        .clk    (clk),
        .reset  (reset),
        .arrive (arrive_ew_left),
        .light  (ew_left_light),
        .count  (q_ew_left),
        .sensor (ew_left_sensor),
        .drop   (w_drop[EW_LEFT])
    );

    approach_queue #(.QDEPTH(QDEPTH), .DEP_GAP(DEP_GAP)) u_q_ns (
        .clk    (clk),
        .reset  (reset),
        .arrive (arrive_ns),
        .light  (ns_light),
        .count  (q_ns),
        .sensor (ns_sensor),
        .drop   (w_drop[NS])
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_overflow <= 1'b0;
        else
            r_overflow <= r_overflow | (|w_drop);
    end

    assign overflow = r_overflow;

`ifdef SAFETY_CHECK_EN
    logic [1:0]              r_prev [NUM_APPROACH];
    logic                    r_conflict;
    logic [NUM_APPROACH-1:0] w_nonred;
    logic                    w_multi;
    logic                    w_undef;
    logic                    w_skip;

    // A green->red step is only detectable against the colour seen last cycle.
    always_comb begin
        w_nonred = '0;
        w_undef  = 1'b0;
        w_skip   = 1'b0;
        for (int unsigned i = 0; i < NUM_APPROACH; i++) begin
            w_nonred[i] = (w_light[i] != red);
            w_undef     = w_undef | (w_light[i] == 2'b11);
            w_skip      = w_skip | ((r_prev[i] == green) && (w_light[i] == red));
        end
    end

    assign w_multi = (w_nonred[0] & w_nonred[1]) |
                     (w_nonred[0] & w_nonred[2]) |
                     (w_nonred[1] & w_nonred[2]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict <= 1'b0;
            for (int unsigned i = 0; i < NUM_APPROACH; i++)
                r_prev[i] <= red;
        end else begin
            r_conflict <= r_conflict | w_multi | w_undef | w_skip;
            for (int unsigned i = 0; i < NUM_APPROACH; i++)
                r_prev[i] <= w_light[i];
        end
    end

    assign conflict = r_conflict;
`else
    assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_intersection_model.sv
// Scoreboard bench for intersection_model: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_intersection_model;
    import light_package::*;

`ifdef SAFETY_CHECK_EN
    localparam int SAFE = 1;
`else
    localparam int SAFE = 0;
`endif

    localparam int S_QSTR = 0, S_QLEFT = 1, S_QNS = 2, S_SENS = 3, S_OVF = 4, S_CONF = 5;

    typedef struct {
        string name;
        int    sel;
        int    exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_str = 1'b0, a_left = 1'b0, a_ns = 1'b0;
    logic [1:0] l_str = red, l_left = red, l_ns = red;
    logic       s_str, s_left, s_ns, ovf, conf;
    logic [2:0] q_str, q_left, q_ns;

    exp_t scb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    intersection_model #(.QDEPTH(7), .DEP_GAP(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .arrive_ew_str  (a_str),
        .arrive_ew_left (a_left),
        .arrive_ns      (a_ns),
        .ew_str_light   (l_str),
        .ew_left_light  (l_left),
        .ns_light       (l_ns),
        .ew_str_sensor  (s_str),
        .ew_left_sensor (s_left),
        .ns_sensor      (s_ns),
        .q_ew_str       (q_str),
        .q_ew_left      (q_left),
        .q_ns           (q_ns),
        .overflow       (ovf),
        .conflict       (conf)
    );

    always #5 clk = ~clk;

    function automatic int actual(input int s);
        case (s)
            S_QSTR:  return int'(q_str);
            S_QLEFT: return int'(q_left);
            S_QNS:   return int'(q_ns);
            S_SENS:  return int'({s_str, s_left, s_ns});
            S_OVF:   return int'(ovf);
            default: return int'(conf);
        endcase
    endfunction

    // Monitor: outputs are settled by the falling edge.
    initial begin
        exp_t e;
        int   a;
        forever begin
            @(negedge clk);
            while (scb.size() > 0) begin
                e = scb.pop_front();
                a = actual(e.sel);
                n_checks++;
                if (a == e.exp)
                    n_pass++;
                else
                    $display("FAIL %s: got %0d, expected %0d", e.name, a, e.exp);
            end
        end
    end

    task automatic expect_val(input string n, input int s, input int e);
        exp_t x;
        x.name = n;
        x.sel  = s;
        x.exp  = e;
        scb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string n);
        expect_val({n, "_qstr"},  S_QSTR,  0);
        expect_val({n, "_qleft"}, S_QLEFT, 0);
        expect_val({n, "_qns"},   S_QNS,   0);
        expect_val({n, "_sens"},  S_SENS,  0);
        expect_val({n, "_ovf"},   S_OVF,   0);
        expect_val({n, "_conf"},  S_CONF,  0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_str = 1'b0; a_left = 1'b0; a_ns = 1'b0;
        l_str = red;  l_left = red;  l_ns = red;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p, k, w;
        logic [1:0] col;

        // Reset state
        do_reset();
        expect_idle("reset");

        // Three arrivals at n-s with all red
        a_ns = 1'b1; tick();
        expect_val("ns_arr1_q", S_QNS, 1);
        expect_val("ns_arr1_sens", S_SENS, 3'b001);
        tick(); tick();
        a_ns = 1'b0;
        expect_val("ns_arr3_q", S_QNS, 3);
        tick(); tick();
        expect_val("ns_hold_red_q", S_QNS, 3);

        // n-s green for 6 cycles: departures on cycles 0, 2, 4
        l_ns = green;
        tick(); expect_val("ns_g0", S_QNS, 2);
        tick(); expect_val("ns_g1", S_QNS, 2);
        tick(); expect_val("ns_g2", S_QNS, 1);
        tick(); expect_val("ns_g3", S_QNS, 1);
        tick(); expect_val("ns_g4", S_QNS, 0);
                expect_val("ns_g4_sens", S_SENS, 0);
        tick(); expect_val("ns_g5_floor", S_QNS, 0);
        l_ns = yellow; tick();
        l_ns = red;    tick();
        expect_val("ns_legal_conf", S_CONF, 0);

        // Fill e-w left to the limit
        a_left = 1'b1;
        repeat (7) tick();
        expect_val("left_full_q", S_QLEFT, 7);
        expect_val("left_full_ovf", S_OVF, 0);
        // Arrival and departure together while full
        l_left = green; tick();
        a_left = 1'b0;
        expect_val("left_arrdep_q", S_QLEFT, 7);
        expect_val("left_arrdep_ovf", S_OVF, 0);
        l_left = yellow; tick(); tick();
        expect_val("left_yellow_hold", S_QLEFT, 7);
        l_left = red; tick();
        a_left = 1'b1; tick();
        a_left = 1'b0;
        expect_val("left_drop_q", S_QLEFT, 7);
        expect_val("left_drop_ovf", S_OVF, 1);
        tick();
        expect_val("left_ovf_sticky", S_OVF, 1);
        // Undefined colour holds cars
        l_left = 2'b11; tick(); tick();
        l_left = red;
        expect_val("left_undef_hold", S_QLEFT, 7);
        expect_val("left_undef_conf", S_CONF, SAFE);

        // Reset mid-operation discards queued cars
        do_reset();
        expect_idle("midreset");

        // Two greens at once
        l_str = green; l_ns = green; tick();
        expect_val("dual_green_conf", S_CONF, SAFE);
        l_str = red; l_ns = red; tick(); tick();
        expect_val("dual_green_sticky", S_CONF, SAFE);

        // Green straight to red without yellow
        do_reset();
        expect_val("skip_pre_conf", S_CONF, 0);
        l_str = green; tick();
        expect_val("single_green_conf", S_CONF, 0);
        l_str = red; tick();
        expect_val("skip_yellow_conf", S_CONF, SAFE);

        // Closed loop: legal rotation, one arrival every 4 cycles round-robin
        do_reset();
        for (int c = 0; c < 168; c++) begin
            p = c % 21;
            k = p / 7;
            w = p % 7;
            col = (w < 6) ? green : yellow;
            l_str  = (k == 0) ? col : red;
            l_left = (k == 1) ? col : red;
            l_ns   = (k == 2) ? col : red;
            a_str  = (c < 100) && (c % 4 == 0) && ((c / 4) % 3 == 0);
            a_left = (c < 100) && (c % 4 == 0) && ((c / 4) % 3 == 1);
            a_ns   = (c < 100) && (c % 4 == 0) && ((c / 4) % 3 == 2);
            tick();
            if (c == 99) begin
                expect_val("loop_mid_ovf", S_OVF, 0);
                expect_val("loop_mid_conf", S_CONF, 0);
            end
        end
        a_str = 1'b0; a_left = 1'b0; a_ns = 1'b0;
        l_str = red;  l_left = red;  l_ns = red;
        tick();
        expect_idle("loop_end");

        @(negedge clk);
        #1;
        n_checks++;
        if (scb.size() == 0)
            n_pass++;
        else
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", scb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
